abuf_phase_seq: RTL and testbench

Phase sequencer for the head core's activation buffer. It walks the layer phases in order: Q_GEN, K_GEN, V_GEN, ATT_QK, ATT_PV, PROJ, FFN0, FFN1. For each enabled phase it issues the `control_state` / `control_state_update` / `start` triple the buffer consumes. It then counts the buffer's `finish_row` pulses and drains before advancing. It sits between the top-level host/config logic and the activation buffer.

---
 rtl/abuf_phase_seq_pkg.sv | 50 +++++
 rtl/abuf_phase_seq_lsb_onehot_sel.sv | 34 +++
 rtl/abuf_phase_seq.sv | 219 +++++++++++++++++++++
 tb/tb_abuf_phase_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/abuf_phase_seq_pkg.sv
// Shared head-core definitions for the activation-buffer phase sequencer:
// the buffer's CONTROL_STATE encoding, the sequencer FSM states and the
// mapping from a phase index (bit position in the phase mask) to the
// CONTROL_STATE value presented to the buffer.
package abuf_phase_seq_pkg;

  // Number of layer phases; one mask bit per phase.
  localparam int NUM_PHASES = 8;

  // Phase presented to the activation buffer. IDLE_STATE parks the buffer
  // between sequences; phase i maps to encoding i+1.
  typedef enum logic [3:0] {
    IDLE_STATE   = 4'd0,
    Q_GEN_STATE  = 4'd1,
    K_GEN_STATE  = 4'd2,
    V_GEN_STATE  = 4'd3,
    ATT_QK_STATE = 4'd4,
    ATT_PV_STATE = 4'd5,
    PROJ_STATE   = 4'd6,
    FFN0_STATE   = 4'd7,
    FFN1_STATE   = 4'd8
  } control_state_t;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UPDATE = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_END    = 3'd5
  } seq_state_t;

  // Phase index (0=Q_GEN .. 7=FFN1) to the buffer's CONTROL_STATE value.
  function automatic control_state_t phase_to_state(input logic [2:0] idx);
    control_state_t cs;
    case (idx)
      3'd0:    cs = Q_GEN_STATE;
      3'd1:    cs = K_GEN_STATE;
      3'd2:    cs = V_GEN_STATE;
      3'd3:    cs = ATT_QK_STATE;
      3'd4:    cs = ATT_PV_STATE;
      3'd5:    cs = PROJ_STATE;
      3'd6:    cs = FFN0_STATE;
      default: cs = FFN1_STATE;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/abuf_phase_seq_lsb_onehot_sel.sv
// Priority finder over the 8-bit phase mask. Returns the lowest set bit
// strictly above after_idx, or the lowest set bit overall when search_all
// is high. sel_valid is low when no qualifying bit exists.
module lsb_onehot_sel (
  input  logic [7:0] mask,
  input  logic [2:0] after_idx,
  input  logic       search_all,
  output logic [2:0] sel_idx,
  output logic       sel_valid
);

  // Mask bits that are candidates for selection.
  logic [7:0] qual;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_qual
      assign qual[gi] = mask[gi] & (search_all | (3'(gi) > after_idx));
    end
  endgenerate

  // Scan from the top down so the lowest qualifying bit is written last and wins.
  always_comb begin
    sel_idx   = 3'd0;
    sel_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (qual[i]) begin
        sel_idx   = 3'(i);
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/abuf_phase_seq.sv
// Phase sequencer for the head core's activation buffer. Walks the enabled
// layer phases in order, presenting each phase to the buffer with an update
// strobe followed one cycle later by start, counts finish_row pulses up to
// the programmed row target, drains for a fixed number of cycles and then
// moves on. Every output is driven straight from a register.
module abuf_phase_seq
  import abuf_phase_seq_pkg::*;
#(
  parameter int unsigned ROW_CNT_WIDTH = 16,
  parameter int unsigned DRAIN_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     abort,
  input  logic [7:0]               phase_mask,
  input  logic [ROW_CNT_WIDTH-1:0] num_rows,
  input  logic                     finish_row,
  output control_state_t           control_state,
  output logic                     control_state_update,
  output logic                     start,
  output logic                     busy,
  output logic [ROW_CNT_WIDTH-1:0] rows_done,
  output logic                     phase_done,
  output logic                     seq_done
);

  // The drain counter is 8 bits wide, so the drain length must fit in 1..255.
  generate
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
      $error("abuf_phase_seq: DRAIN_CYCLES must be in the range 1..255");
    end
  endgenerate

  localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE    = {{(ROW_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0]               DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  // FSM and sequence context.
  seq_state_t               state_reg, state_next;
  logic [7:0]               mask_reg, mask_next;
  logic [ROW_CNT_WIDTH-1:0] rows_q_reg, rows_q_next;
  logic [2:0]               cur_phase_reg, cur_phase_next;
  logic [7:0]               drain_reg, drain_next;

  // Registered outputs.
  control_state_t           cs_reg, cs_next;
  logic                     update_reg, update_next;
  logic                     start_reg, start_next;
  logic                     busy_reg, busy_next;
  logic [ROW_CNT_WIDTH-1:0] rows_done_reg, rows_done_next;
  logic                     phase_done_reg, phase_done_next;
  logic                     seq_done_reg, seq_done_next;

  // Phase selection: first phase straight from the incoming mask on run,
  // next phase from the latched mask above the current phase during drain.
  logic [2:0] first_idx, next_idx;
  logic       first_valid, next_valid;

  lsb_onehot_sel u_first_sel (
    .mask       (phase_mask),
    .after_idx  (3'd0),
    .search_all (1'b1),
    .sel_idx    (first_idx),
    .sel_valid  (first_valid)
  );

  lsb_onehot_sel u_next_sel (
    .mask       (mask_reg),
    .after_idx  (cur_phase_reg),
    .search_all (1'b0),
    .sel_idx    (next_idx),
    .sel_valid  (next_valid)
  );

  // State and output registers; asynchronous reset parks the buffer at IDLE_STATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      mask_reg       <= '0;
      rows_q_reg     <= '0;
      cur_phase_reg  <= '0;
      drain_reg      <= '0;
      cs_reg         <= IDLE_STATE;
      update_reg     <= 1'b0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      rows_done_reg  <= '0;
      phase_done_reg <= 1'b0;
      seq_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      rows_q_reg     <= rows_q_next;
      cur_phase_reg  <= cur_phase_next;
      drain_reg      <= drain_next;
      cs_reg         <= cs_next;
      update_reg     <= update_next;
      start_reg      <= start_next;
      busy_reg       <= busy_next;
      rows_done_reg  <= rows_done_next;
      phase_done_reg <= phase_done_next;
      seq_done_reg   <= seq_done_next;
    end
  end

  // Next-state logic. Output strobes are computed for the state being
  // entered, so they are visible in the same cycle as that state.
  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    rows_q_next     = rows_q_reg;
    cur_phase_next  = cur_phase_reg;
    drain_next      = drain_reg;
    cs_next         = cs_reg;
    update_next     = 1'b0;
    start_next      = 1'b0;
    rows_done_next  = rows_done_reg;
    phase_done_next = 1'b0;
    seq_done_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (run && !abort) begin
          mask_next   = phase_mask;
          rows_q_next = num_rows;
          if (!first_valid || num_rows == '0) begin
            // Nothing to do: close the sequence immediately.
            state_next    = S_END;
            cs_next       = IDLE_STATE;
            update_next   = 1'b1;
            seq_done_next = 1'b1;
          end else begin
            state_next     = S_UPDATE;
            cur_phase_next = first_idx;
            cs_next        = phase_to_state(first_idx);
            update_next    = 1'b1;
            rows_done_next = '0;
          end
        end
      end

      S_UPDATE: begin
        // The buffer already holds the new phase, so its start samples it.
        state_next = S_START;
        start_next = 1'b1;
      end

      S_START: begin
        state_next = S_RUN;
      end

      S_RUN: begin
        if (finish_row) begin
          if (rows_done_reg == rows_q_reg - ROW_ONE) begin
            rows_done_next  = rows_q_reg;
            phase_done_next = 1'b1;
            drain_next      = DRAIN_LOAD;
            state_next      = S_DRAIN;
          end else begin
            rows_done_next = rows_done_reg + ROW_ONE;
          end
        end
      end

      S_DRAIN: begin
        // Stray finish_row pulses are ignored while draining.
        if (drain_reg == 8'd0) begin
          if (next_valid) begin
            state_next     = S_UPDATE;
            cur_phase_next = next_idx;
            cs_next        = phase_to_state(next_idx);
            update_next    = 1'b1;
            rows_done_next = '0;
          end else begin
            state_next    = S_END;
            cs_next       = IDLE_STATE;
            update_next   = 1'b1;
            seq_done_next = 1'b1;
          end
        end else begin
          drain_next = drain_reg - 8'd1;
        end
      end

      S_END: begin
        // A run arriving here is dropped; the host must re-issue it.
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort beats every other event once a sequence is active.
    if (state_reg != S_IDLE && abort) begin
      state_next      = S_END;
      cs_next         = IDLE_STATE;
      update_next     = 1'b1;
      start_next      = 1'b0;
      phase_done_next = 1'b0;
      seq_done_next   = 1'b0;
      rows_done_next  = rows_done_reg;
      cur_phase_next  = cur_phase_reg;
      drain_next      = drain_reg;
    end

    busy_next = (state_next != S_IDLE);
  end

  assign control_state        = cs_reg;
  assign control_state_update = update_reg;
  assign start                = start_reg;
  assign busy                 = busy_reg;
  assign rows_done            = rows_done_reg;
  assign phase_done           = phase_done_reg;
  assign seq_done             = seq_done_reg;

endmodule

// File: tb/tb_abuf_phase_seq.sv
// Directed-plus-random bench for abuf_phase_seq. Expected outputs come from
// the sequencing and timing rules: for each enabled phase an update, a
// start one cycle later, row counting, a phase_done one cycle after the last
// row, a fixed drain, then the next update or the closing IDLE_STATE update.
module tb_abuf_phase_seq;
  import abuf_phase_seq_pkg::*;

  localparam int RW    = 16;
  localparam int DRAIN = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           run = 1'b0;
  logic           abort = 1'b0;
  logic           finish_row = 1'b0;
  logic [7:0]     phase_mask = '0;
  logic [RW-1:0]  num_rows = '0;
  control_state_t control_state;
  logic           control_state_update;
  logic           start;
  logic           busy;
  logic [RW-1:0]  rows_done;
  logic           phase_done;
  logic           seq_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: what the buffer should currently be told.
  logic [3:0]    exp_cs = 4'd0;
  logic [RW-1:0] exp_rows = '0;

  abuf_phase_seq #(
    .ROW_CNT_WIDTH (RW),
    .DRAIN_CYCLES  (DRAIN)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .run                  (run),
    .abort                (abort),
    .phase_mask           (phase_mask),
    .num_rows             (num_rows),
    .finish_row           (finish_row),
    .control_state        (control_state),
    .control_state_update (control_state_update),
    .start                (start),
    .busy                 (busy),
    .rows_done            (rows_done),
    .phase_done           (phase_done),
    .seq_done             (seq_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_out(input string where, input logic e_upd, input logic e_st,
                         input logic e_pd, input logic e_sd, input logic e_busy);
    chk1({where, ".control_state"}, 32'(control_state), 32'(exp_cs));
    chk1({where, ".update"}, 32'(control_state_update), 32'(e_upd));
    chk1({where, ".start"}, 32'(start), 32'(e_st));
    chk1({where, ".phase_done"}, 32'(phase_done), 32'(e_pd));
    chk1({where, ".seq_done"}, 32'(seq_done), 32'(e_sd));
    chk1({where, ".busy"}, 32'(busy), 32'(e_busy));
    chk1({where, ".rows_done"}, 32'(rows_done), 32'(exp_rows));
    $display("step %-20s cyc=%0d cs=%0d upd=%0b start=%0b pd=%0b sd=%0b busy=%0b rows=%0d",
             where, cyc, control_state, control_state_update, start, phase_done,
             seq_done, busy, rows_done);
  endtask

  // Called in the S_END cycle: a run pulse here must be dropped.
  task automatic end_tail();
    run = 1'b1; phase_mask = 8'hFF; num_rows = RW'(1);
    tick();
    run = 1'b0;
    chk_out("end_to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("run_in_end_dropped", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // kind: 0 = run to completion, 1 = abort, 2 = async reset,
  // applied in phase at_phase before its (at_row+1)-th row.
  task automatic do_seq(input logic [7:0] mask, input logic [RW-1:0] rows,
                        input int kind, input int at_phase, input int at_row);
    int gap;
    phase_mask = mask; num_rows = rows; run = 1'b1;
    tick();
    run = 1'b0; phase_mask = 8'($urandom); num_rows = RW'($urandom);
    if (mask == 8'd0 || rows == '0) begin
      exp_cs = 4'd0;
      chk_out("degenerate_end", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      end_tail();
      return;
    end
    for (int p = 0; p < 8; p++) begin
      if (!mask[p]) continue;
      exp_cs = 4'(p + 1);
      exp_rows = '0;
      chk_out("update", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      finish_row = 1'($urandom);
      tick();
      chk_out("start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      finish_row = 1'($urandom);
      tick();
      finish_row = 1'b0;
      chk_out("run_entry", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int r = 0; r < int'(rows); r++) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          run = 1'($urandom); phase_mask = 8'($urandom); num_rows = RW'($urandom);
          tick();
          run = 1'b0;
          chk_out("run_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (kind != 0 && p == at_phase && r == at_row) begin
          if (kind == 1) begin
            abort = 1'b1; finish_row = 1'b1;
            tick();
            abort = 1'b0; finish_row = 1'b0;
            exp_cs = 4'd0;
            chk_out("abort_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            chk_out("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          end else begin
            rst_n = 1'b0;
            #2;
            exp_cs = 4'd0; exp_rows = '0;
            chk_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #2 rst_n = 1'b1;
            tick();
            chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          end
          return;
        end
        finish_row = 1'b1;
        tick();
        finish_row = 1'b0;
        exp_rows = exp_rows + RW'(1);
        chk_out("row", 1'b0, 1'b0, (r == int'(rows) - 1), 1'b0, 1'b1);
      end
      for (int d = 1; d < DRAIN; d++) begin
        finish_row = 1'($urandom);
        tick();
        chk_out("drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      finish_row = 1'($urandom);
      tick();
      finish_row = 1'b0;
    end
    exp_cs = 4'd0;
    chk_out("seq_end", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end_tail();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_cs = 4'd0; exp_rows = '0;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_seq(8'hFF, RW'(3), 0, 0, 0);          // full sequence
    do_seq(8'b1000_0101, RW'(3), 0, 0, 0);   // sparse mask
    do_seq(8'hFF, RW'(0), 0, 0, 0);          // zero rows
    do_seq(8'h00, RW'(5), 0, 0, 0);          // empty mask
    do_seq(8'hFF, RW'(3), 1, 3, 1);          // abort in ATT_QK after one row
    do_seq(8'hFF, RW'(3), 2, 6, 1);          // reset in FFN0
    do_seq(8'hFF, RW'(2), 0, 0, 0);          // restart after reset
    do_seq(8'h01, RW'(1), 0, 0, 0);          // single phase, single row
    for (int i = 0; i < 8; i++) begin
      do_seq(8'($urandom), RW'($urandom_range(1, 4)), 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
